// File: rtl/fadd_arbiter_if.sv
// Requester, result and adder-side signals of the shared floating-point adder arbiter.
// slave is the arbiter's view; master is the client/adder-environment view.
interface fadd_arbiter_if #(
  parameter int N    = 16,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   res_valid;
  logic [NREQ-1:0]   res_ready;
  logic [NREQ*N-1:0] res_data;
  logic [N-1:0]      add_a;
  logic [N-1:0]      add_b;
  logic              add_issue;
  logic              add_ready;
  logic [N-1:0]      add_sum;
  logic              busy;

  modport slave (
    input  req_valid, req_a, req_b, res_ready, add_ready, add_sum,
    output req_ready, res_valid, res_data, add_a, add_b, add_issue, busy
  );

  modport master (
    output req_valid, req_a, req_b, res_ready, add_ready, add_sum,
    input  req_ready, res_valid, res_data, add_a, add_b, add_issue, busy
  );
endinterface

// File: rtl/fadd_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined adder among NREQ requesters;
// a tag pipeline follows each op so its sum lands in the issuing requester's result register.
module fadd_arbiter #(
  parameter int N    = 16,
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  logic          clock,
  input  logic          reset,
  fadd_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  typedef logic [IDW-1:0] id_t;

  logic [NREQ-1:0]   r_pend;
  logic [NREQ-1:0]   r_res_valid;
  logic [NREQ*N-1:0] r_res_data;
  id_t               r_ptr;
  logic [LAT-1:0]    r_tag_vld;
  id_t               r_tag_id [LAT];

  logic [NREQ-1:0]   w_elig;
  logic [NREQ-1:0]   w_grant;
  logic              w_found;
  id_t               w_gid;
  id_t               w_ptr_nxt;
  logic [NREQ-1:0]   w_consume;
  logic              w_cap;
  id_t               w_cap_id;
  logic [NREQ-1:0]   w_cap_oh;

  // No grants while reset is held, so no phantom op reaches the adder.
  assign w_elig = bus.req_valid & ~r_pend & {NREQ{bus.add_ready & ~reset}};

  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    w_found = 1'b0;
    w_gid   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && w_elig[idx]) begin
        w_grant[idx] = 1'b1;
        w_found      = 1'b1;
        w_gid        = id_t'(idx);
      end
    end
  end

  assign w_ptr_nxt = (w_gid == id_t'(NREQ - 1)) ? '0 : w_gid + 1'b1;

  assign bus.req_ready = w_grant;
  assign bus.add_issue = w_found;
  assign bus.add_a     = w_found ? bus.req_a[int'(w_gid)*N +: N] : '0;
  assign bus.add_b     = w_found ? bus.req_b[int'(w_gid)*N +: N] : '0;

  assign w_cap     = r_tag_vld[LAT-1];
  assign w_cap_id  = r_tag_id[LAT-1];
  assign w_consume = r_res_valid & bus.res_ready;

  always_comb begin
    w_cap_oh = '0;
    if (w_cap) w_cap_oh[w_cap_id] = 1'b1;
  end

  // Control state: pending flags, result-full flags, rr pointer, tag valids
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend      <= '0;
      r_res_valid <= '0;
      r_ptr       <= '0;
      r_tag_vld   <= '0;
    end else begin
      r_pend      <= (r_pend & ~w_consume) | w_grant;
      r_res_valid <= (r_res_valid & ~w_consume) | w_cap_oh;
      if (w_found) r_ptr <= w_ptr_nxt;
      r_tag_vld[0] <= w_found;
      for (int s = 1; s < LAT; s++) r_tag_vld[s] <= r_tag_vld[s-1];
    end
  end

  // Tag ids shift in lockstep with the adder, regardless of add_ready
  always_ff @(posedge clock) begin
    r_tag_id[0] <= w_gid;
    for (int s = 1; s < LAT; s++) r_tag_id[s] <= r_tag_id[s-1];
  end

  // Result capture at the adder output stage
  always_ff @(posedge clock) begin
    if (reset) begin
      r_res_data <= '0;
    end else if (w_cap) begin
      r_res_data[int'(w_cap_id)*N +: N] <= bus.add_sum;
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.busy      = |r_pend;

  a_no_overwrite: assert property (@(posedge clock) disable iff (reset)
    w_cap |-> !r_res_valid[w_cap_id]);

endmodule

// File: tb/tb_fadd_arbiter.sv
// Randomized bench for fadd_arbiter with a stub adder, a cycle-level reference model
// of grants/result timing, and a result scoreboard checked at each consumption.
module tb_fadd_arbiter;
  localparam int N    = 16;
  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fadd_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

  fadd_arbiter #(.N(N), .NREQ(NREQ), .LAT(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stub adder: equal operands double (exponent + 1), otherwise a byte-swap mix.
  function automatic logic [N-1:0] stub_sum(input logic [N-1:0] a, input logic [N-1:0] b);
    return (a == b) ? a + 16'h0080 : a ^ {b[7:0], b[15:8]};
  endfunction

  logic [LAT-1:0] s_v = '0;
  logic [N-1:0]   s_a [LAT];
  logic [N-1:0]   s_b [LAT];
  logic [N-1:0]   s_junk = '0;

  always @(posedge clock) begin
    s_v[0] <= bus.add_issue;
    s_a[0] <= bus.add_a;
    s_b[0] <= bus.add_b;
    for (int s = 1; s < LAT; s++) begin
      s_v[s] <= s_v[s-1];
      s_a[s] <= s_a[s-1];
      s_b[s] <= s_b[s-1];
    end
    s_junk <= N'($urandom);
  end

  assign bus.add_sum = s_v[LAT-1] ? stub_sum(s_a[LAT-1], s_b[LAT-1]) : s_junk;

  typedef struct { int id; int due; } fl_t;
  typedef struct { int id; logic [N-1:0] data; } exp_t;

  fl_t  fl_q[$];
  exp_t exp_q[$];
  int   act_log[$];
  bit [NREQ-1:0] m_pend = '0;
  bit [NREQ-1:0] m_resv = '0;
  int   m_ptr = 0;

  // Reference model: predicts grant, operand mux, result timing and busy each cycle.
  always @(negedge clock) begin
    bit [NREQ-1:0] exp_gnt;
    logic [N-1:0]  ea, eb;
    int g;
    exp_gnt = '0;
    g  = -1;
    ea = '0;
    eb = '0;
    if (bus.add_issue)
      for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) act_log.push_back(i);
    if (reset) begin
      m_pend = '0;
      m_resv = '0;
      m_ptr  = 0;
      fl_q.delete();
      exp_q.delete();
      check("req_ready_in_reset", bus.req_ready, '0);
    end else begin
      for (int q = fl_q.size() - 1; q >= 0; q--)
        if (fl_q[q].due == cyc) begin
          m_resv[fl_q[q].id] = 1'b1;
          fl_q.delete(q);
        end
      check("res_valid", bus.res_valid, m_resv);
      check("busy", bus.busy, |m_pend);
      if (bus.add_ready)
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (m_ptr + k) % NREQ;
          if (g < 0 && bus.req_valid[i] && !m_pend[i]) g = i;
        end
      if (g >= 0) begin
        exp_gnt[g] = 1'b1;
        ea = bus.req_a[g*N +: N];
        eb = bus.req_b[g*N +: N];
      end
      check("req_ready", bus.req_ready, exp_gnt);
      check("add_issue", bus.add_issue, g >= 0);
      check("add_a", bus.add_a, ea);
      check("add_b", bus.add_b, eb);
      for (int i = 0; i < NREQ; i++)
        if (m_resv[i] && bus.res_ready[i]) begin
          m_resv[i] = 1'b0;
          m_pend[i] = 1'b0;
        end
      if (g >= 0) begin
        fl_t  f;
        exp_t e;
        f.id   = g;
        f.due  = cyc + LAT + 1;
        e.id   = g;
        e.data = stub_sum(ea, eb);
        m_pend[g] = 1'b1;
        m_ptr     = (g + 1) % NREQ;
        fl_q.push_back(f);
        exp_q.push_back(e);
      end
    end
  end

  // Scoreboard monitor: pops the expected sum whenever a result is handed over.
  always @(negedge clock) begin
    if (!reset)
      for (int i = 0; i < NREQ; i++)
        if (bus.res_valid[i] && bus.res_ready[i]) begin
          int idx;
          idx = -1;
          for (int q = 0; q < exp_q.size(); q++) if (idx < 0 && exp_q[q].id == i) idx = q;
          if (idx < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL res_data[%0d]: got %0h, expected no result (cycle %0d)",
                     i, bus.res_data[i*N +: N], cyc);
          end else begin
            check($sformatf("res_data[%0d]", i), bus.res_data[i*N +: N], exp_q[idx].data);
            exp_q.delete(idx);
          end
        end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*N +: N] = N'($urandom);
      bus.req_b[i*N +: N] = N'($urandom);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    int bad;
    bus.req_valid = '0;
    bus.res_ready = '0;
    bus.add_ready = 1'b1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    @(negedge clock);
    check("rst_res_valid", bus.res_valid, '0);
    check("rst_res_data", bus.res_data, '0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_add_issue", bus.add_issue, 1'b0);

    // Single op on requester 0
    tick(1);
    bus.res_ready = '1;
    bus.req_a[0 +: N] = 16'h3F80;
    bus.req_b[0 +: N] = 16'h3F80;
    bus.req_valid = 4'b0001;
    @(negedge clock);
    check("single_grant", bus.req_ready, 4'b0001);
    tick(1);
    bus.req_valid = '0;
    lat = 0;
    do begin
      lat++;
      @(negedge clock);
    end while (!bus.res_valid[0] && lat < 10);
    check("single_latency", lat, LAT + 1);
    check("single_data", bus.res_data[0 +: N], 16'h4000);
    check("single_busy_hi", bus.busy, 1'b1);
    @(negedge clock);
    check("single_clear_valid", bus.res_valid[0], 1'b0);
    check("single_clear_busy", bus.busy, 1'b0);

    // All requesting from ptr = 0
    tick(1);
    do_reset();
    base = act_log.size();
    bus.req_valid = '1;
    bus.res_ready = '1;
    for (int c = 0; c < 24; c++) begin
      set_ops();
      tick(1);
    end
    for (int k = 0; k < 4; k++)
      check($sformatf("rr_order_%0d", k), (act_log.size() > base + k) ? act_log[base + k] : -1, k);

    // Backpressure on requester 2
    bus.res_ready = 4'b1011;
    for (int c = 0; c < 10; c++) begin
      set_ops();
      tick(1);
    end
    @(negedge clock);
    check("bp_hold_valid2", bus.res_valid[2], 1'b1);
    tick(1);
    bus.res_ready = '1;
    for (int c = 0; c < 10; c++) begin
      set_ops();
      tick(1);
    end

    // Adder stalls with ops in flight
    bus.add_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("stall_issue", bus.add_issue, 1'b0);
      check("stall_ready", bus.req_ready, '0);
      tick(1);
    end
    bus.add_ready = 1'b1;
    tick(6);

    // Reset right after a grant
    bus.req_valid = '0;
    tick(8);
    bus.req_valid = 4'b0100;
    @(negedge clock);
    check("rst_mid_grant", bus.req_ready, 4'b0100);
    tick(1);
    bus.req_valid = '0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid_valid", bus.res_valid, '0);
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_ready", bus.req_ready, '0);
    tick(5);
    bus.req_valid = '1;
    @(negedge clock);
    check("post_rst_first", bus.req_ready, 4'b0001);

    // Sparse fairness: only 1 and 3
    tick(1);
    do_reset();
    base = act_log.size();
    bus.req_valid = 4'b1010;
    for (int c = 0; c < 20; c++) begin
      set_ops();
      tick(1);
    end
    for (int k = 0; k < 4; k++)
      check($sformatf("sparse_order_%0d", k),
            (act_log.size() > base + k) ? act_log[base + k] : -1, (k % 2 == 0) ? 1 : 3);
    bad = 0;
    for (int q = base; q < act_log.size(); q++) if (act_log[q] == 0 || act_log[q] == 2) bad++;
    check("sparse_no_0_2", bad, 0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      bus.req_valid = NREQ'($urandom);
      bus.res_ready = NREQ'($urandom);
      bus.add_ready = ($urandom_range(0, 7) != 0);
      set_ops();
      tick(1);
    end

    bus.req_valid = '0;
    bus.res_ready = '1;
    bus.add_ready = 1'b1;
    tick(10);
    @(negedge clock);
    check("drain_busy", bus.busy, 1'b0);
    check("drain_scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
